// File: rtl/axi_pipeline_addsub_if.sv
// Stream bundle for the chunk-pipelined add/sub unit.
// "slave" is the arithmetic block's view: it sinks s_axi_* beats and sources m_axi_* beats.
interface axi_pipeline_addsub_if #(
    parameter int DWIDTH = 64,
    parameter int UWIDTH = 1
);
    logic              s_axi_valid;
    logic              s_axi_ready;
    logic [DWIDTH-1:0] s_axi_data_a;
    logic [DWIDTH-1:0] s_axi_data_b;
    logic              s_axi_op;
    logic              s_axi_cin;
    logic [UWIDTH-1:0] s_axi_user;

    logic              m_axi_valid;
    logic              m_axi_ready;
    logic [DWIDTH-1:0] m_axi_data_a;
    logic [DWIDTH-1:0] m_axi_data_b;
    logic              m_axi_op;
    logic [DWIDTH-1:0] m_axi_data_result;
    logic              m_axi_data_carry;
    logic              m_axi_overflow;
    logic              m_axi_zero;
    logic [UWIDTH-1:0] m_axi_user;

    modport slave (
        input  s_axi_valid, s_axi_data_a, s_axi_data_b, s_axi_op, s_axi_cin, s_axi_user,
        input  m_axi_ready,
        output s_axi_ready,
        output m_axi_valid, m_axi_data_a, m_axi_data_b, m_axi_op, m_axi_data_result,
        output m_axi_data_carry, m_axi_overflow, m_axi_zero, m_axi_user
    );

    modport master (
        output s_axi_valid, s_axi_data_a, s_axi_data_b, s_axi_op, s_axi_cin, s_axi_user,
        output m_axi_ready,
        input  s_axi_ready,
        input  m_axi_valid, m_axi_data_a, m_axi_data_b, m_axi_op, m_axi_data_result,
        input  m_axi_data_carry, m_axi_overflow, m_axi_zero, m_axi_user
    );
endinterface

// File: rtl/axi_pipeline_addsub.sv
// Chunk-pipelined adder/subtractor. Stage k resolves one CHUNK_SZ slice and hands
// its carry to stage k+1. Every stage has its own advance signal, so bubbles
// collapse forward while the output is stalled instead of freezing the whole pipe.
// SUB is computed as A + ~B + ~cin, which makes the final carry a "no borrow" flag.
module axi_pipeline_addsub #(
    parameter int DWIDTH   = 64,
    parameter int CHUNK_SZ = 16,
    parameter int UWIDTH   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_pipeline_addsub_if.slave bus
);
    if (CHUNK_SZ < 1 || DWIDTH < 1) begin : g_param_check
        $error("axi_pipeline_addsub: CHUNK_SZ and DWIDTH must both be >= 1");
    end

    localparam int NUM_CHUNKS = (DWIDTH + CHUNK_SZ - 1) / CHUNK_SZ;
    localparam int LAST       = NUM_CHUNKS - 1;

    logic [NUM_CHUNKS-1:0] w_v;
    logic [NUM_CHUNKS:0]   w_adv;
    logic                  r_ovf;

    // A stage may load when it is empty or everything downstream of it can move;
    // written as a running OR from the output back so there is no feedback loop.
    always_comb begin : p_adv
        logic w_acc;
        w_acc             = bus.m_axi_ready;
        w_adv[NUM_CHUNKS] = bus.m_axi_ready;
        for (int k = NUM_CHUNKS - 1; k >= 0; k--) begin
            w_acc    = w_acc | ~w_v[k];
            w_adv[k] = w_acc;
        end
    end

    for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_st
        localparam int LO = k * CHUNK_SZ;
        // Top chunk may be narrower, so its carry lands exactly at bit DWIDTH.
        localparam int W  = (k == NUM_CHUNKS - 1) ? DWIDTH - LO : CHUNK_SZ;

        logic              r_v, r_op, r_c, r_z;
        logic [DWIDTH-1:0] r_a, r_b, r_res;
        logic [UWIDTH-1:0] r_user;

        logic              w_vin, w_opin, w_cin, w_zin;
        logic [DWIDTH-1:0] w_ain, w_bin, w_resin, w_resnext;
        logic [UWIDTH-1:0] w_userin;
        logic [W-1:0]      w_ac, w_bc;
        logic [W:0]        w_sum;

        if (k == 0) begin : g_src
            assign w_vin    = bus.s_axi_valid;
            assign w_ain    = bus.s_axi_data_a;
            assign w_bin    = bus.s_axi_data_b;
            assign w_opin   = bus.s_axi_op;
            assign w_userin = bus.s_axi_user;
            assign w_cin    = bus.s_axi_op ? ~bus.s_axi_cin : bus.s_axi_cin;
            assign w_resin  = '0;
            assign w_zin    = 1'b1;
        end else begin : g_src
            assign w_vin    = g_st[k-1].r_v;
            assign w_ain    = g_st[k-1].r_a;
            assign w_bin    = g_st[k-1].r_b;
            assign w_opin   = g_st[k-1].r_op;
            assign w_userin = g_st[k-1].r_user;
            assign w_cin    = g_st[k-1].r_c;
            assign w_resin  = g_st[k-1].r_res;
            assign w_zin    = g_st[k-1].r_z;
        end

        assign w_ac  = w_ain[LO +: W];
        assign w_bc  = w_opin ? ~w_bin[LO +: W] : w_bin[LO +: W];
        assign w_sum = {1'b0, w_ac} + {1'b0, w_bc} + {{W{1'b0}}, w_cin};

        // Splice this stage's chunk into the partially built result.
        always_comb begin
            w_resnext           = w_resin;
            w_resnext[LO +: W]  = w_sum[W-1:0];
        end

        // Stage register: load on advance, otherwise hold every field.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_v    <= 1'b0;
                r_op   <= 1'b0;
                r_c    <= 1'b0;
                r_z    <= 1'b0;
                r_a    <= '0;
                r_b    <= '0;
                r_res  <= '0;
                r_user <= '0;
            end else if (w_adv[k]) begin
                r_v    <= w_vin;
                r_op   <= w_opin;
                r_c    <= w_sum[W];
                r_z    <= w_zin & (w_sum[W-1:0] == '0);
                r_a    <= w_ain;
                r_b    <= w_bin;
                r_res  <= w_resnext;
                r_user <= w_userin;
            end
        end

        assign w_v[k] = r_v;
    end

    // Signed overflow only makes sense once the MSB chunk is resolved, so it
    // lives beside the last stage and advances with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_adv[LAST]) begin
            r_ovf <= (g_st[LAST].w_ain[DWIDTH-1] ==
                      (g_st[LAST].w_opin ^ g_st[LAST].w_bin[DWIDTH-1])) &
                     (g_st[LAST].w_resnext[DWIDTH-1] != g_st[LAST].w_ain[DWIDTH-1]);
        end
    end

    assign bus.s_axi_ready       = w_adv[0];
    assign bus.m_axi_valid       = g_st[LAST].r_v;
    assign bus.m_axi_data_a      = g_st[LAST].r_a;
    assign bus.m_axi_data_b      = g_st[LAST].r_b;
    assign bus.m_axi_op          = g_st[LAST].r_op;
    assign bus.m_axi_data_result = g_st[LAST].r_res;
    assign bus.m_axi_data_carry  = g_st[LAST].r_c;
    assign bus.m_axi_overflow    = r_ovf;
    assign bus.m_axi_zero        = g_st[LAST].r_z;
    assign bus.m_axi_user        = g_st[LAST].r_user;
endmodule
